relu_forward: RTL and testbench

- Forward ReLU stage of the FPU tensor pipeline. Produces the activation tensor that the backward ReLU stage later consumes together with the gradient.
- Reads a tensor (header + FP32 elements) through memory handle a. Copies the header verbatim to handle d, then writes max(0,x) per element to d.
- Optionally also writes a sign mask to handle b for the backward pass.

---
 rtl/fpu_pkg.sv | 19 +
 rtl/mem_req_ctl.sv | 83 ++++++++
 rtl/relu_forward.sv | 201 ++++++++++++++++++++
 tb/tb_relu_forward.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU tensor pipeline stages: state encoding for
// the forward ReLU sequencer and the FP32 constants it emits.
package fpu_pkg;

    typedef enum logic [2:0] {
        WAIT,
        HDR_N,
        HDR_CP,
        LOOP,
        RD,
        WR,
        DONE
    } relu_fwd_state_t;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;
    localparam int          SIGN_BIT  = 31;

endpackage

// File: rtl/mem_req_ctl.sv
// Per-handle memory request controller: raises a read or write request, holds
// it until the memory answers, then latches read data and steps the pointer.
module mem_req_ctl
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_l,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] wdata,
    input  logic        ld_ptr,
    input  logic [31:0] ptr_init,
    input  logic        mem_done,
    input  logic [31:0] data_load,
    output logic        r_en,
    output logic        w_en,
    output logic        avail,
    output logic [31:0] ptr,
    output logic [31:0] data_store,
    output logic        cpl,
    output logic [31:0] rdata
);

    logic        r_en_q, r_en_d;
    logic        w_en_q, w_en_d;
    logic        avail_q, avail_d;
    logic [31:0] ptr_q, ptr_d;
    logic [31:0] data_store_q, data_store_d;
    logic [31:0] rdata_q, rdata_d;

    // A new request is only accepted while idle, so at most one is ever open.
    always_comb begin
        r_en_d       = r_en_q;
        w_en_d       = w_en_q;
        avail_d      = avail_q;
        ptr_d        = ptr_q;
        data_store_d = data_store_q;
        rdata_d      = rdata_q;
        cpl          = avail_q && mem_done;
        if (ld_ptr) begin
            ptr_d = ptr_init;
        end
        if (!avail_q && req) begin
            avail_d      = 1'b1;
            r_en_d       = !wr;
            w_en_d       = wr;
            data_store_d = wdata;
        end
        if (cpl) begin
            avail_d = 1'b0;
            r_en_d  = 1'b0;
            w_en_d  = 1'b0;
            ptr_d   = ptr_q + 32'd1;
            rdata_d = data_load;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_en_q       <= 1'b0;
            w_en_q       <= 1'b0;
            avail_q      <= 1'b0;
            ptr_q        <= 32'd0;
            data_store_q <= 32'd0;
            rdata_q      <= 32'd0;
        end else begin
            r_en_q       <= r_en_d;
            w_en_q       <= w_en_d;
            avail_q      <= avail_d;
            ptr_q        <= ptr_d;
            data_store_q <= data_store_d;
            rdata_q      <= rdata_d;
        end
    end

    assign r_en       = r_en_q;
    assign w_en       = w_en_q;
    assign avail      = avail_q;
    assign ptr        = ptr_q;
    assign data_store = data_store_q;
    assign rdata      = rdata_q;

endmodule

// File: rtl/relu_forward.sv
// Forward ReLU stage: copies the tensor header from a to d, then writes max(0,x)
// per element. Define RELU_FWD_MASK_EN to also emit a sign mask on handle b.
module relu_forward
    import fpu_pkg::*;
#(
    parameter int MAX_DIMS = 2
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        go,
    output logic        a_r_en,
    output logic        a_w_en,
    output logic        a_avail,
    output logic [31:0] a_ptr,
    output logic [31:0] a_data_store,
    input  logic [31:0] a_data_load,
    input  logic        a_done,
    input  logic [31:0] a_region_begin,
    input  logic [31:0] a_region_end,
    output logic        b_r_en,
    output logic        b_w_en,
    output logic        b_avail,
    output logic [31:0] b_ptr,
    output logic [31:0] b_data_store,
    input  logic        b_done,
    input  logic [31:0] b_region_begin,
    input  logic [31:0] b_region_end,
    output logic        d_r_en,
    output logic        d_w_en,
    output logic        d_avail,
    output logic [31:0] d_ptr,
    output logic [31:0] d_data_store,
    input  logic        d_done,
    input  logic [31:0] d_region_begin,
    input  logic [31:0] d_region_end,
    output logic        done,
    output logic        err,
    output logic [31:0] count
);

`ifdef RELU_FWD_MASK_EN
    localparam bit mask_en = 1'b1;
`else
    localparam bit mask_en = 1'b0;
`endif

    relu_fwd_state_t state_q;
    logic [31:0] nd_q, idx_q, hold_q, x_q, count_q;
    logic        err_q;
    logic        a_iss_q, a_ok_q, d_iss_q, d_ok_q, b_iss_q, b_ok_q;
    logic        a_need, d_need, b_need, a_req, d_req, b_req, step_ok, ld_ptr;
    logic        a_cpl, d_cpl, b_cpl;
    logic [31:0] a_rdata, d_rdata, b_rdata, d_wdata, b_wdata, y, mask;
    logic        unused_ok;

    // Each step needs some set of handles; a step is over once every one of
    // them has reported completion, in whatever order the memories answer.
    always_comb begin
        y       = x_q[SIGN_BIT] ? FP32_ZERO : x_q;
        mask    = x_q[SIGN_BIT] ? FP32_ZERO : FP32_ONE;
        a_need  = (state_q == HDR_N) || (state_q == RD) ||
                  ((state_q == HDR_CP) && (idx_q < nd_q));
        d_need  = (state_q == HDR_CP) || (state_q == WR);
        b_need  = mask_en && d_need;
        a_req   = a_need && !a_iss_q;
        d_req   = d_need && !d_iss_q;
        b_req   = b_need && !b_iss_q;
        step_ok = (!a_need || a_ok_q) && (!d_need || d_ok_q) && (!b_need || b_ok_q);
        d_wdata = (state_q == WR) ? y : hold_q;
        b_wdata = (state_q == WR) ? mask : hold_q;
        ld_ptr  = (state_q == WAIT) && go;
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q <= WAIT;
            err_q   <= 1'b0;
            count_q <= 32'd0;
            nd_q    <= 32'd0;
            idx_q   <= 32'd0;
            hold_q  <= 32'd0;
            x_q     <= 32'd0;
            a_iss_q <= 1'b0;
            a_ok_q  <= 1'b0;
            d_iss_q <= 1'b0;
            d_ok_q  <= 1'b0;
            b_iss_q <= 1'b0;
            b_ok_q  <= 1'b0;
        end else begin
            if (a_req) a_iss_q <= 1'b1;
            if (a_cpl) a_ok_q  <= 1'b1;
            if (d_req) d_iss_q <= 1'b1;
            if (d_cpl) d_ok_q  <= 1'b1;
            if (b_req) b_iss_q <= 1'b1;
            if (b_cpl) b_ok_q  <= 1'b1;
            if (step_ok && (a_need || d_need)) begin
                a_iss_q <= 1'b0;
                a_ok_q  <= 1'b0;
                d_iss_q <= 1'b0;
                d_ok_q  <= 1'b0;
                b_iss_q <= 1'b0;
                b_ok_q  <= 1'b0;
            end
            case (state_q)
                WAIT: begin
                    if (go) begin
                        err_q   <= 1'b0;
                        count_q <= 32'd0;
                        state_q <= HDR_N;
                    end
                end
                HDR_N: begin
                    if (step_ok) begin
                        nd_q   <= a_rdata;
                        hold_q <= a_rdata;
                        idx_q  <= 32'd0;
                        if ((a_rdata == 32'd0) || (a_rdata > 32'(MAX_DIMS))) begin
                            err_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= HDR_CP;
                        end
                    end
                end
                // Word idx goes out on d while word idx+1 comes in from a.
                HDR_CP: begin
                    if (step_ok) begin
                        hold_q <= a_rdata;
                        idx_q  <= idx_q + 32'd1;
                        if (idx_q == nd_q) state_q <= LOOP;
                    end
                end
                LOOP: begin
                    if (d_ptr == d_region_end) begin
                        state_q <= DONE;
                    end else if (a_ptr == a_region_end) begin
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= RD;
                    end
                end
                RD: begin
                    if (step_ok) begin
                        x_q     <= a_rdata;
                        state_q <= WR;
                    end
                end
                WR: begin
                    if (step_ok) begin
                        count_q <= count_q + 32'd1;
                        state_q <= LOOP;
                    end
                end
                DONE: begin
                    if (!go) state_q <= WAIT;
                end
                default: state_q <= WAIT;
            endcase
        end
    end

    mem_req_ctl u_a_ctl (
        .clk(clk), .rst_l(rst_l), .req(a_req), .wr(1'b0), .wdata(32'd0),
        .ld_ptr(ld_ptr), .ptr_init(a_region_begin), .mem_done(a_done),
        .data_load(a_data_load), .r_en(a_r_en), .w_en(a_w_en), .avail(a_avail),
        .ptr(a_ptr), .data_store(a_data_store), .cpl(a_cpl), .rdata(a_rdata)
    );

    mem_req_ctl u_d_ctl (
        .clk(clk), .rst_l(rst_l), .req(d_req), .wr(1'b1), .wdata(d_wdata),
        .ld_ptr(ld_ptr), .ptr_init(d_region_begin), .mem_done(d_done),
        .data_load(32'd0), .r_en(d_r_en), .w_en(d_w_en), .avail(d_avail),
        .ptr(d_ptr), .data_store(d_data_store), .cpl(d_cpl), .rdata(d_rdata)
    );

`ifdef RELU_FWD_MASK_EN
    // b walks in lockstep with d, so its pointer offset always matches d's.
    mem_req_ctl u_b_ctl (
        .clk(clk), .rst_l(rst_l), .req(b_req), .wr(1'b1), .wdata(b_wdata),
        .ld_ptr(ld_ptr), .ptr_init(b_region_begin), .mem_done(b_done),
        .data_load(32'd0), .r_en(b_r_en), .w_en(b_w_en), .avail(b_avail),
        .ptr(b_ptr), .data_store(b_data_store), .cpl(b_cpl), .rdata(b_rdata)
    );
`else
    assign b_r_en       = 1'b0;
    assign b_w_en       = 1'b0;
    assign b_avail      = 1'b0;
    assign b_ptr        = 32'd0;
    assign b_data_store = 32'd0;
    assign b_cpl        = 1'b0;
    assign b_rdata      = 32'd0;
`endif

    assign unused_ok = ^{b_done, b_region_begin, b_region_end, d_rdata, b_rdata, b_wdata};

    assign done  = (state_q == DONE);
    assign err   = err_q;
    assign count = count_q;

endmodule

// File: tb/tb_relu_forward.sv
// Scoreboard bench for relu_forward: memory models with random done latency on
// every handle, expected d/b words queued from a reference model at start.
module tb_relu_forward;

    localparam int          MAX_DIMS = 2;
    localparam logic [31:0] A_BASE   = 32'h0000_0100;
    localparam logic [31:0] D_BASE   = 32'h0000_0200;
    localparam logic [31:0] B_BASE   = 32'h0000_0300;

    logic        clk = 1'b0;
    logic        rst_l, go;
    logic        a_r_en, a_w_en, a_avail, a_done;
    logic [31:0] a_ptr, a_data_store, a_data_load, a_region_begin, a_region_end;
    logic        b_r_en, b_w_en, b_avail, b_done;
    logic [31:0] b_ptr, b_data_store, b_region_begin, b_region_end;
    logic        d_r_en, d_w_en, d_avail, d_done;
    logic [31:0] d_ptr, d_data_store, d_region_begin, d_region_end;
    logic        done, err;
    logic [31:0] count;

    int checkCount = 0;
    int passCount  = 0;

    logic [31:0] amem [64];
    logic [31:0] expD [$];
    logic [31:0] expB [$];
    int  dIdx = 0, bIdx = 0, extraD = 0, extraB = 0, dropCount = 0;
    int  aLat = 0, dLat = 0, bLat = 0, maxLat = 0;
    bit  holdD = 1'b0, monitorOn = 1'b0;
    bit  aPrev = 1'b0, dPrev = 1'b0, bPrev = 1'b0;

    always #5 clk = ~clk;

    relu_forward #(.MAX_DIMS(MAX_DIMS)) dut (
        .clk(clk), .rst_l(rst_l), .go(go),
        .a_r_en(a_r_en), .a_w_en(a_w_en), .a_avail(a_avail), .a_ptr(a_ptr),
        .a_data_store(a_data_store), .a_data_load(a_data_load), .a_done(a_done),
        .a_region_begin(a_region_begin), .a_region_end(a_region_end),
        .b_r_en(b_r_en), .b_w_en(b_w_en), .b_avail(b_avail), .b_ptr(b_ptr),
        .b_data_store(b_data_store), .b_done(b_done),
        .b_region_begin(b_region_begin), .b_region_end(b_region_end),
        .d_r_en(d_r_en), .d_w_en(d_w_en), .d_avail(d_avail), .d_ptr(d_ptr),
        .d_data_store(d_data_store), .d_done(d_done),
        .d_region_begin(d_region_begin), .d_region_end(d_region_end),
        .done(done), .err(err), .count(count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    endtask

    // Memory model for a: answers reads after a random latency.
    always @(negedge clk) begin
        logic [31:0] off;
        if (monitorOn && aPrev && !a_avail && !a_done) dropCount++;
        aPrev = a_avail;
        if (a_done) begin
            a_done = 1'b0;
            aLat = $urandom_range(maxLat, 0);
        end else if (a_avail && a_r_en) begin
            if (aLat == 0) begin
                off = a_ptr - A_BASE;
                a_data_load = amem[off[5:0]];
                a_done = 1'b1;
            end else aLat--;
        end
    end

    // Memory model for d: scoreboard compare on every accepted write.
    always @(negedge clk) begin
        if (monitorOn && dPrev && !d_avail && !d_done) dropCount++;
        dPrev = d_avail;
        if (d_done) begin
            d_done = 1'b0;
            dLat = $urandom_range(maxLat, 0);
        end else if (d_avail && d_w_en && !(holdD && (d_ptr - D_BASE) >= 32'd2)) begin
            if (dLat == 0) begin
                d_done = 1'b1;
                checkOutput("d_ptr", d_ptr, D_BASE + 32'(dIdx));
                if (expD.size() > 0) checkOutput("d_data", d_data_store, expD.pop_front());
                else extraD++;
                dIdx++;
            end else dLat--;
        end
    end

    always @(negedge clk) begin
        if (monitorOn && bPrev && !b_avail && !b_done) dropCount++;
        bPrev = b_avail;
        if (b_done) begin
            b_done = 1'b0;
            bLat = $urandom_range(maxLat, 0);
        end else if (b_avail && b_w_en) begin
            if (bLat == 0) begin
                b_done = 1'b1;
                checkOutput("b_ptr", b_ptr, B_BASE + 32'(bIdx));
                if (expB.size() > 0) checkOutput("b_data", b_data_store, expB.pop_front());
                else extraB++;
                bIdx++;
            end else bLat--;
        end
    end

    task automatic loadA(input logic [31:0] v [8]);
        for (int i = 0; i < 64; i++) amem[i] = (i < 8) ? v[i] : 32'h0;
    endtask

    task automatic applyStimulus(input string name, input int aLen, input int dLen);
        logic [31:0] expCount;
        logic [31:0] x;
        logic        expErr;
        int n, ai, di, cyc;
        expD.delete(); expB.delete();
        dIdx = 0; bIdx = 0; extraD = 0; extraB = 0; dropCount = 0;
        a_region_end = A_BASE + 32'(aLen);
        d_region_end = D_BASE + 32'(dLen);
        b_region_end = B_BASE + 32'(dLen);
        expCount = 32'd0;
        expErr = 1'b0;
        n = int'(amem[0]);
        if (n == 0 || n > MAX_DIMS) expErr = 1'b1;
        else begin
            for (int i = 0; i <= n; i++) begin
                expD.push_back(amem[i]);
                expB.push_back(amem[i]);
            end
            ai = n + 1;
            di = n + 1;
            while (di != dLen) begin
                if (ai == aLen) begin
                    expErr = 1'b1;
                    break;
                end
                x = amem[ai];
                expD.push_back(x[31] ? 32'h0 : x);
                expB.push_back(x[31] ? 32'h0 : 32'h3F80_0000);
                ai++; di++; expCount++;
            end
        end
`ifndef RELU_FWD_MASK_EN
        expB.delete();
`endif
        monitorOn = 1'b1;
        @(negedge clk);
        go = 1'b1;
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({name, "_finished"}, 32'(cyc < 3000), 32'd1);
        checkOutput({name, "_count"}, count, expCount);
        checkOutput({name, "_err"}, 32'(err), 32'(expErr));
        checkOutput({name, "_d_left"}, 32'(expD.size()), 32'd0);
        checkOutput({name, "_b_left"}, 32'(expB.size()), 32'd0);
        checkOutput({name, "_extra"}, 32'(extraD + extraB), 32'd0);
        checkOutput({name, "_no_drop"}, 32'(dropCount), 32'd0);
        checkOutput({name, "_a_no_write"}, 32'(a_w_en), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput({name, "_done_held"}, 32'(done), 32'd1);
        go = 1'b0;
        @(negedge clk);
        checkOutput({name, "_done_clear"}, 32'(done), 32'd0);
    endtask

    task automatic runSet(input int lat);
        logic [31:0] t1 [8] = '{32'd1, 32'd4, 32'h3F80_0000, 32'hC000_0000, 32'h8000_0000, 32'h4060_0000, 32'h0, 32'h0};
        logic [31:0] t2 [8] = '{32'd2, 32'd2, 32'd2, 32'hBF80_0000, 32'hC120_0000, 32'h8000_0000, 32'hFFC0_0000, 32'h0};
        maxLat = lat;
        loadA(t1);
        applyStimulus("mixed", 6, 6);
        loadA(t2);
        applyStimulus("negatives", 7, 7);
    endtask

    initial begin
        logic [31:0] t3 [8] = '{32'd3, 32'd2, 32'd2, 32'd2, 32'h3F80_0000, 32'h0, 32'h0, 32'h0};
        logic [31:0] t4 [8] = '{32'd1, 32'd0, 32'h3F80_0000, 32'h4000_0000, 32'h0, 32'h0, 32'h0, 32'h0};
        logic [31:0] t5 [8] = '{32'd1, 32'd4, 32'h4000_0000, 32'hC040_0000, 32'h0, 32'h0, 32'h0, 32'h0};
        logic [31:0] t1 [8] = '{32'd1, 32'd4, 32'h3F80_0000, 32'hC000_0000, 32'h8000_0000, 32'h4060_0000, 32'h0, 32'h0};
        int cyc;
        rst_l = 1'b0; go = 1'b0;
        a_done = 1'b0; b_done = 1'b0; d_done = 1'b0; a_data_load = 32'h0;
        a_region_begin = A_BASE; b_region_begin = B_BASE; d_region_begin = D_BASE;
        a_region_end = A_BASE; b_region_end = B_BASE; d_region_end = D_BASE;
        repeat (3) @(negedge clk);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_count", count, 32'd0);
        checkOutput("rst_lines", 32'({a_r_en, a_w_en, a_avail, b_r_en, b_w_en, b_avail, d_r_en, d_w_en, d_avail}), 32'd0);
        checkOutput("rst_ptrs", a_ptr | b_ptr | d_ptr | d_data_store | b_data_store, 32'd0);
        rst_l = 1'b1;
        @(negedge clk);

        runSet(0);
        loadA(t3);
        applyStimulus("bad_dims", 8, 8);
        loadA(t4);
        applyStimulus("header_only", 6, 2);
        loadA(t5);
        applyStimulus("a_overrun", 4, 6);

        // Reset while the first element write is stalled.
        loadA(t1);
        holdD = 1'b1;
        monitorOn = 1'b1;
        expD.delete(); dIdx = 0; bIdx = 0;
        a_region_end = A_BASE + 32'd6; d_region_end = D_BASE + 32'd6; b_region_end = B_BASE + 32'd6;
        go = 1'b1;
        cyc = 0;
        while (!(d_avail && d_ptr == D_BASE + 32'd2) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("stall_reached", 32'(cyc < 500), 32'd1);
        repeat (2) @(negedge clk);
        checkOutput("stall_held", 32'(d_avail && d_w_en), 32'd1);
        monitorOn = 1'b0;
        go = 1'b0;
        rst_l = 1'b0;
        @(negedge clk);
        checkOutput("midrst_lines", 32'({a_r_en, a_w_en, a_avail, b_r_en, b_w_en, b_avail, d_r_en, d_w_en, d_avail}), 32'd0);
        checkOutput("midrst_count", count, 32'd0);
        checkOutput("midrst_ptr", d_ptr, 32'd0);
        rst_l = 1'b1;
        holdD = 1'b0;
        repeat (2) @(negedge clk);
        aPrev = 1'b0; dPrev = 1'b0; bPrev = 1'b0;
        applyStimulus("after_reset", 6, 6);

        runSet(5);
        $display("[TB] random latency runs complete");
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
